// File: rtl/writeback_arbiter_pkg.sv
// Shared cpu definitions for the writeback path: register id and data widths,
// the writeback packet layout, and the round-robin pointer advance helper.
package writeback_arbiter_pkg;

   localparam int VREG_W = 5;
   localparam int XLEN   = 32;

   typedef struct packed {
      logic [VREG_W-1:0] vregid;
      logic [XLEN-1:0]   val;
   } wb_pkt_t;

   // Next round-robin start position after granting idx among n producers.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_req_fifo: per-producer result buffer, DEPTH entries (power of two).
// With WB_ARB_FLUSH_EN defined a flush input empties the buffer and drops that edge's push.
module wb_req_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef WB_ARB_FLUSH_EN
   input  logic                     flush,
`endif
   input  logic                     push,
   input  wb_pkt_t                  push_pkt,
   input  logic                     pop,
   output wb_pkt_t                  head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_pkt_t          mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

`ifdef WB_ARB_FLUSH_EN
   assign do_push = push && (count != CNT_W'(DEPTH)) && !flush;
   assign do_pop  = pop && (count != '0) && !flush;
`else
   assign do_push = push && (count != CNT_W'(DEPTH));
   assign do_pop  = pop && (count != '0);
`endif

   assign head = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end
`ifdef WB_ARB_FLUSH_EN
      else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end
`endif
      else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; only entries below count are ever read out.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_pkt;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter merging NREQ buffered result producers onto one registered writeback broadcast.
// Optional feature: define WB_ARB_FLUSH_EN to add a synchronous flush input.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef WB_ARB_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic [NREQ-1:0]           req_valid,
   input  logic [VREG_W*NREQ-1:0]    req_vregid,
   input  logic [XLEN*NREQ-1:0]      req_val,
   output logic [NREQ-1:0]           req_ready,
   output logic                      wb_en,
   output logic [VREG_W-1:0]         wb_vregid,
   output logic [XLEN-1:0]           wb_val,
   output logic [$clog2(NREQ)-1:0]   wb_src
);

   localparam int SRC_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0] count [NREQ];
   wb_pkt_t          head  [NREQ];
   logic [NREQ-1:0]  nonempty;
   logic [NREQ-1:0]  push;
   logic [NREQ-1:0]  pop;
   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] grant_idx;
   logic             grant_valid;
   wb_pkt_t          grant_pkt;
   int               scan;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
      wb_pkt_t push_pkt;

      // Ready depends only on the registered count, never on this cycle's inputs.
      assign req_ready[gi] = (count[gi] != CNT_W'(DEPTH));
      assign nonempty[gi]  = (count[gi] != '0);
      assign push[gi]      = req_valid[gi] && req_ready[gi];
      assign pop[gi]       = grant_valid && (grant_idx == SRC_W'(gi));
      assign push_pkt      = {req_vregid[gi*VREG_W +: VREG_W], req_val[gi*XLEN +: XLEN]};

      wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
`ifdef WB_ARB_FLUSH_EN
         .flush    (flush),
`endif
         .push     (push[gi]),
         .push_pkt (push_pkt),
         .pop      (pop[gi]),
         .head     (head[gi]),
         .count    (count[gi])
      );
   end

   // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan        = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan = (int'(rr_ptr) + k) % NREQ;
         if (nonempty[SRC_W'(scan)]) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'(scan);
         end
      end
   end

   assign grant_pkt = head[grant_idx];

   // Data fields hold their last broadcast when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en     <= 1'b0;
         wb_vregid <= '0;
         wb_val    <= '0;
         wb_src    <= '0;
         rr_ptr    <= '0;
      end
`ifdef WB_ARB_FLUSH_EN
      else if (flush) begin
         wb_en  <= 1'b0;
         rr_ptr <= '0;
      end
`endif
      else if (grant_valid) begin
         wb_en     <= 1'b1;
         wb_vregid <= grant_pkt.vregid;
         wb_val    <= grant_pkt.val;
         wb_src    <= grant_idx;
         rr_ptr    <= SRC_W'(rr_next(int'(grant_idx), NREQ));
      end
      else begin
         wb_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model. Flush scenarios need WB_ARB_FLUSH_EN.
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int DEPTH = 2;

   logic                    clk;
   logic                    rst_n;
`ifdef WB_ARB_FLUSH_EN
   logic                    flush;
`endif
   logic [NREQ-1:0]         req_valid;
   logic [VREG_W*NREQ-1:0]  req_vregid;
   logic [XLEN*NREQ-1:0]    req_val;
   logic [NREQ-1:0]         req_ready;
   logic                    wb_en;
   logic [VREG_W-1:0]       wb_vregid;
   logic [XLEN-1:0]         wb_val;
   logic [$clog2(NREQ)-1:0] wb_src;

   writeback_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef WB_ARB_FLUSH_EN
      .flush      (flush),
`endif
      .req_valid  (req_valid),
      .req_vregid (req_vregid),
      .req_val    (req_val),
      .req_ready  (req_ready),
      .wb_en      (wb_en),
      .wb_vregid  (wb_vregid),
      .wb_val     (wb_val),
      .wb_src     (wb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int num_checks = 0;
   int num_fails  = 0;

   // Reference model: one queue per producer plus the expected broadcast registers.
   logic [VREG_W+XLEN-1:0] mq [NREQ][$];
   int                     m_rr;
   logic                   exp_en;
   logic [VREG_W-1:0]      exp_vregid;
   logic [XLEN-1:0]        exp_val;
   int                     exp_src;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_rr       = 0;
      exp_en     = 1'b0;
      exp_vregid = '0;
      exp_val    = '0;
      exp_src    = 0;
   endtask

   // Drives one cycle of inputs, advances the model across the edge, then checks outputs.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [VREG_W*NREQ-1:0] ids,
                                input logic [XLEN*NREQ-1:0] vals, input logic fl);
      logic [NREQ-1:0]        rdy;
      logic [VREG_W+XLEN-1:0] pkt;
      int                     g;
      req_valid  = v;
      req_vregid = ids;
      req_val    = vals;
`ifdef WB_ARB_FLUSH_EN
      flush      = fl;
`endif
      for (int i = 0; i < NREQ; i++) rdy[i] = (mq[i].size() < DEPTH);
      checkOutput("req_ready", 64'(req_ready), 64'(rdy));
      g = -1;
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && mq[(m_rr + k) % NREQ].size() > 0) g = (m_rr + k) % NREQ;
      if (fl) begin
         for (int i = 0; i < NREQ; i++) mq[i].delete();
         exp_en = 1'b0;
         m_rr   = 0;
      end else begin
         if (g >= 0) begin
            pkt        = mq[g].pop_front();
            exp_en     = 1'b1;
            exp_vregid = pkt[XLEN +: VREG_W];
            exp_val    = pkt[XLEN-1:0];
            exp_src    = g;
            m_rr       = (g + 1) % NREQ;
         end else begin
            exp_en = 1'b0;
         end
         for (int i = 0; i < NREQ; i++)
            if (v[i] && rdy[i]) mq[i].push_back({ids[i*VREG_W +: VREG_W], vals[i*XLEN +: XLEN]});
      end
      @(posedge clk);
      #1;
      checkOutput("wb_en", 64'(wb_en), 64'(exp_en));
      checkOutput("wb_vregid", 64'(wb_vregid), 64'(exp_vregid));
      checkOutput("wb_val", 64'(wb_val), 64'(exp_val));
      checkOutput("wb_src", 64'(wb_src), 64'(exp_src));
   endtask

   task automatic idleCycles(input int n);
      for (int c = 0; c < n; c++) applyStimulus('0, '0, '0, 1'b0);
   endtask

   logic [VREG_W*NREQ-1:0] ids;
   logic [XLEN*NREQ-1:0]   vals;
   logic                   fl;
   logic                   saw_drop;
   int                     n;

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_vregid = '0;
      req_val    = '0;
`ifdef WB_ARB_FLUSH_EN
      flush      = 1'b0;
`endif
      modelReset();

      // Reset values while rst_n is held low.
      #2;
      checkOutput("reset_wb_en", 64'(wb_en), 64'd0);
      checkOutput("reset_wb_vregid", 64'(wb_vregid), 64'd0);
      checkOutput("reset_wb_val", 64'(wb_val), 64'd0);
      checkOutput("reset_wb_src", 64'(wb_src), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_ready", 64'(req_ready), 64'hF);

      // Fairness: all producers push every cycle, grants rotate 0,1,2,3.
      n = 0;
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            ids[i*VREG_W +: VREG_W] = VREG_W'(c + i);
            vals[i*XLEN +: XLEN]    = XLEN'(c * 16 + i);
         end
         applyStimulus('1, ids, vals, 1'b0);
         if (wb_en) begin
            checkOutput("fair_src", 64'(wb_src), 64'(n % NREQ));
            n++;
         end
      end
      checkOutput("fair_count", 64'(n), 64'd15);
      idleCycles(12);

      // Single push from producer 2.
      ids  = '0;
      vals = '0;
      ids[2*VREG_W +: VREG_W] = 5'd7;
      vals[2*XLEN +: XLEN]    = 32'hDEADBEEF;
      applyStimulus(4'b0100, ids, vals, 1'b0);
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput("single_en", 64'(wb_en), 64'd1);
      checkOutput("single_vregid", 64'(wb_vregid), 64'd7);
      checkOutput("single_val", 64'(wb_val), 64'hDEADBEEF);
      checkOutput("single_src", 64'(wb_src), 64'd2);
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput("single_en_off", 64'(wb_en), 64'd0);

      // Ordering: producer 3 sends vregid 1 then 2.
      ids = '0;
      ids[3*VREG_W +: VREG_W] = 5'd1;
      applyStimulus(4'b1000, ids, '0, 1'b0);
      ids[3*VREG_W +: VREG_W] = 5'd2;
      applyStimulus(4'b1000, ids, '0, 1'b0);
      checkOutput("order_first", 64'(wb_vregid), 64'd1);
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput("order_second", 64'(wb_vregid), 64'd2);
      idleCycles(4);

      // Backpressure: a lone producer never stalls; saturation fills its buffer.
      for (int c = 0; c < 8; c++) begin
         vals = '0;
         vals[1*XLEN +: XLEN] = XLEN'(32'h100 + c);
         applyStimulus(4'b0010, '0, vals, 1'b0);
         checkOutput("bp_ready1", 64'(req_ready[1]), 64'd1);
      end
      saw_drop = 1'b0;
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < NREQ; i++) vals[i*XLEN +: XLEN] = XLEN'(32'h200 + c * 4 + i);
         applyStimulus('1, '0, vals, 1'b0);
         if (!req_ready[1]) saw_drop = 1'b1;
      end
      checkOutput("bp_drop", 64'(saw_drop), 64'd1);
      idleCycles(12);

      // Reset mid-operation with a broadcast in flight and 3 entries buffered.
      for (int i = 0; i < NREQ; i++) vals[i*XLEN +: XLEN] = XLEN'(32'h300 + i);
      applyStimulus('1, '0, vals, 1'b0);
      applyStimulus('0, '0, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wb_en", 64'(wb_en), 64'd0);
      checkOutput("midrst_wb_val", 64'(wb_val), 64'd0);
      checkOutput("midrst_wb_src", 64'(wb_src), 64'd0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_no_stale", 64'(wb_en), 64'd0);
      checkOutput("midrst_ready", 64'(req_ready), 64'hF);
      idleCycles(3);

`ifdef WB_ARB_FLUSH_EN
      // Flush with two entries buffered while producer 0 pushes.
      vals = '0;
      vals[1*XLEN +: XLEN] = 32'h11;
      vals[2*XLEN +: XLEN] = 32'h22;
      applyStimulus(4'b0110, '0, vals, 1'b0);
      vals[0 +: XLEN] = 32'h33;
      applyStimulus(4'b0001, '0, vals, 1'b1);
      checkOutput("flush_en", 64'(wb_en), 64'd0);
      idleCycles(3);
      for (int i = 0; i < NREQ; i++) vals[i*XLEN +: XLEN] = XLEN'(32'h400 + i);
      applyStimulus('1, '0, vals, 1'b0);
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput("flush_rr_src", 64'(wb_src), 64'd0);
      idleCycles(8);
`endif

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            ids[i*VREG_W +: VREG_W] = VREG_W'($urandom);
            vals[i*XLEN +: XLEN]    = $urandom;
         end
         fl = 1'b0;
`ifdef WB_ARB_FLUSH_EN
         fl = ($urandom_range(0, 15) == 0);
`endif
         applyStimulus(NREQ'($urandom_range(0, 15)), ids, vals, fl);
      end
      idleCycles(12);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of result producers sharing one writeback channel.
REQ-002 SHALL have parameter DEPTH, default 2, per-producer buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  producer i offers a result.
REQ-006 SHALL have port req_vregid  input  5*NREQ  destination virtual register id; slice i = bits [5i+4:5i].
REQ-007 SHALL have port req_val  input  32*NREQ  result value; slice i = bits [32i+31:32i].
REQ-008 SHALL have port req_ready  output  NREQ  producer i's buffer can accept this cycle.
REQ-009 SHALL have port wb_en  output  1  broadcast valid.
REQ-010 SHALL have port wb_vregid  output  5  broadcast register id.
REQ-011 SHALL have port wb_val  output  32  broadcast value.
REQ-012 SHALL have port wb_src  output  $clog2(NREQ)  index of the producer being broadcast.

Function
REQ-013 SHALL accept a result from producer i at a rising edge iff req_valid[i] and req_ready[i]; the push goes to producer i's FIFO tail.
REQ-014 SHALL drive req_ready[i] purely from registered state: high iff FIFO i count < DEPTH (no combinational path from any input).
REQ-015 SHALL, each cycle, select at most one non-empty FIFO round-robin, searching from rr_ptr upward with modulo-NREQ wrap.
REQ-016 SHALL pop the selected FIFO head at the edge and register it onto wb_en/wb_vregid/wb_val/wb_src; outputs are registered.
REQ-017 SHALL set rr_ptr to (granted index + 1) mod NREQ after a grant; rr_ptr holds when nothing is granted.
REQ-018 SHALL deassert wb_en in any cycle following an edge with no grant; wb_vregid/wb_val/wb_src then hold their prior values.
REQ-019 SHALL have minimum latency of 2 edges: push at edge t, broadcast visible after edge t+1; no bypass from req_* to wb_*.
REQ-020 SHALL support push and pop on the same FIFO in one edge; count unchanged, order preserved.
REQ-021 SHALL keep per-FIFO order strictly first-in-first-out; no ordering is guaranteed across producers.
REQ-022 SHALL ignore req_valid[i] when req_ready[i] is low; the dropped offer leaves no state change.
REQ-023 SHALL guarantee that with all FIFOs continuously non-empty each producer is granted exactly once per NREQ cycles.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH, with count in 0..DEPTH.

Reset
REQ-025 SHALL, while rst_n is low, immediately force wb_en=0, wb_vregid=0, wb_val=0, wb_src=0, rr_ptr=0, all FIFO counts and pointers=0.
REQ-026 SHALL drive req_ready to all-ones from the first edge after rst_n deasserts; entries buffered when reset asserts mid-operation are discarded.

Configuration
REQ-027 SHALL, with WB_ARB_FLUSH_EN defined, add input flush (1 bit); when high at an edge, all FIFOs empty, wb_en=0 next cycle, rr_ptr=0, and that edge's pushes are dropped.
REQ-028 SHALL, without WB_ARB_FLUSH_EN, have no flush port and no flush logic.

Structure
REQ-029 SHALL take VREG_W=5, XLEN=32 and the writeback packet typedef (vregid, val) from the shared cpu package.
REQ-030 SHALL implement each buffer as a sub-module wb_req_fifo (DEPTH entries, push/pop/count, async active-low reset), instantiated NREQ times.

Verification
REQ-031 Single push: producer 2 pushes vregid 7, val 0xDEADBEEF at edge 1 -> wb_en=1, wb_vregid=7, wb_val=0xDEADBEEF, wb_src=2 after edge 2, wb_en=0 after edge 3.
REQ-032 Fairness: all four producers push every cycle for 16 cycles -> wb_src sequence 0,1,2,3 repeating; no producer skipped.
REQ-033 Backpressure: only producer 1 offers every cycle, DEPTH=2 -> req_ready[1] stays high (push/pop balance); with producers 0..3 all saturating, req_ready[1] drops after its FIFO fills; no value lost or duplicated.
REQ-034 Ordering: producer 3 pushes vregids 1,2 back-to-back -> broadcast vregid 1 before 2.
REQ-035 Reset mid-operation: rst_n low with FIFOs holding 3 entries -> wb_en=0 immediately, no stale broadcast after rst_n high.
REQ-036 Flush (WB_ARB_FLUSH_EN): flush with 2 entries buffered and producer 0 pushing -> no broadcast of any of them, rr_ptr=0.
